// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding and shared constants for the front-end hazard sequencer.
package hazard_pkg;
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_FREEZE   = 2'd1,
        HZ_REDIRECT = 2'd2
    } hz_state_t;
    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer: saturating dmem_wait counter with a sticky timeout flag.
module hazard_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int W        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic count,
    output logic timeout_err
);
    logic [W-1:0] wait_cnt;
    logic         at_max;
    assign at_max = wait_cnt == W'(MAX_WAIT);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= start ? W'(1) : count ? (at_max ? wait_cnt : wait_cnt + 1'b1) : '0;
            if (count && at_max) timeout_err <= 1'b1;
        end
    end
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: PC/IF-ID/ID-EX stall, flush and freeze control for the front end.
// Optional HAZ_PERF_CNT_EN adds stall/flush/freeze event counters.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Jump,
    input  logic                  EX_BranchTaken,
    input  logic                  dmem_wait,
    output logic                  pc_write,
    output logic                  stall_IF_ID,
    output logic                  flush_IF,
    output logic                  flush_ID_EX,
    output logic                  freeze,
    output logic                  timeout_err,
    output logic [1:0]            state_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events,
    output logic [31:0]           freeze_cycles
`endif
);
    hz_state_t state, state_nx;
    logic      pend_redir, pend_nx;
    logic      is_freeze, is_redir, hold, redir, load_use;
    assign is_freeze = state == HZ_FREEZE;
    assign is_redir  = state == HZ_REDIRECT;
    assign load_use  = EX_MemRead && EX_Rt != REG_ADDR_W'(ZERO_REG) &&
                       (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
    // A memory wait overrides everything, including a redirect in progress.
    assign hold  = dmem_wait || is_freeze;
    assign redir = is_redir || EX_BranchTaken;
    assign pc_write    = !reset && !hold && (redir || !load_use);
    assign stall_IF_ID = !reset && (hold || (!redir && load_use));
    assign freeze      = !reset && hold;
    assign flush_IF    = reset || (!hold && (redir || (!load_use && ID_Jump)));
    assign flush_ID_EX = reset || (!hold && (redir || load_use));
    assign state_o     = state;
    // Encoding 3 falls through to the RUN path.
    assign state_nx = dmem_wait ? HZ_FREEZE :
                      (is_freeze && (pend_redir || EX_BranchTaken)) ? HZ_REDIRECT : HZ_RUN;
    assign pend_nx  = dmem_wait && (is_freeze ? (pend_redir || EX_BranchTaken) :
                                    is_redir || EX_BranchTaken);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HZ_RUN;
            pend_redir <= 1'b0;
        end else begin
            state      <= state_nx;
            pend_redir <= pend_nx;
        end
    end
    hazard_wait_timer #(.MAX_WAIT(MAX_WAIT), .W(WAIT_CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (dmem_wait && !is_freeze),
        .count      (dmem_wait && is_freeze),
        .timeout_err(timeout_err)
    );
`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles  <= '0;
            flush_events  <= '0;
            freeze_cycles <= '0;
        end else begin
            stall_cycles  <= stall_cycles + 32'(stall_IF_ID);
            flush_events  <= flush_events + 32'(flush_IF);
            freeze_cycles <= freeze_cycles + 32'(freeze);
        end
    end
`endif
endmodule
